// File: rtl/xcver_rst_seq.sv
// xcver_rst_seq: powerdown, PLL-lock qualification, TX reset and per-lane RX reset sequencer.
// Define XCVR_SYNC_DEBOUNCE_EN to require DEBOUNCE_CYC consecutive low sync cycles before an up lane drops.
module xcver_rst_seq #(
    parameter int LANES            = 2,
    parameter int PWR_DN_CYC       = 16,
    parameter int LOCK_WAIT_CYC    = 1000,
    parameter int RX_ANA_RST_CYC   = 64,
    parameter int SYNC_TIMEOUT_CYC = 65535,
    parameter int MAX_RETRY        = 3,
    parameter int DEBOUNCE_CYC     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic             pll_locked,
    input  logic             reconfig_busy,
    input  logic [LANES-1:0] sync_status,
    output logic             gxb_pwr_dwn,
    output logic             tx_digital_rst,
    output logic             tx_ready,
    output logic [LANES-1:0] rx_analog_rst,
    output logic [LANES-1:0] rx_digital_rst,
    output logic [LANES-1:0] rx_ready,
    output logic [LANES-1:0] lane_fail,
    output logic [3:0]       retry_cnt
);
    localparam int TMAX  = PWR_DN_CYC > LOCK_WAIT_CYC ? PWR_DN_CYC : LOCK_WAIT_CYC;
    localparam int LMAX0 = RX_ANA_RST_CYC > SYNC_TIMEOUT_CYC ? RX_ANA_RST_CYC : SYNC_TIMEOUT_CYC;
    localparam int LMAX  = LMAX0 > DEBOUNCE_CYC ? LMAX0 : DEBOUNCE_CYC;
    localparam int TW    = $clog2(TMAX + 1);
    localparam int LW    = $clog2(LMAX + 1);
    localparam logic [TW-1:0] PWR_END   = TW'(PWR_DN_CYC - 1);
    localparam logic [TW-1:0] LOCK_END  = TW'(LOCK_WAIT_CYC - 1);
    localparam logic [LW-1:0] ANA_END   = LW'(RX_ANA_RST_CYC - 1);
    localparam logic [LW-1:0] TO_END    = LW'(SYNC_TIMEOUT_CYC - 1);
    localparam logic [3:0]    RETRY_END = 4'(MAX_RETRY);
`ifdef XCVR_SYNC_DEBOUNCE_EN
    localparam logic [LW-1:0] DEB_END   = LW'(DEBOUNCE_CYC - 1);
`endif

    typedef enum logic [1:0] {PWRDN, WAIT_LOCK, TX_UP} top_t;
    typedef enum logic [2:0] {RX_IDLE, RX_ANA, RX_WAIT, RX_UP, RX_FAIL} lane_t;

    top_t          st, st_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    lane_t         ls        [LANES];
    lane_t         ls_nxt    [LANES];
    logic [LW-1:0] lcnt      [LANES];
    logic [LW-1:0] lcnt_nxt  [LANES];
    logic [3:0]    retry     [LANES];
    logic [3:0]    retry_nxt [LANES];
    logic          restart_q, qual, lock_lost, tx_go;

    function automatic logic [TW-1:0] tinc(input logic [TW-1:0] v);
        return v + TW'(v != '1);
    endfunction

    function automatic logic [LW-1:0] linc(input logic [LW-1:0] v);
        return v + LW'(v != '1);
    endfunction

    function automatic logic [3:0] rinc(input logic [3:0] v);
        return v + 4'(v != '1);
    endfunction

    assign qual      = pll_locked & ~reconfig_busy;
    assign lock_lost = st == TX_UP && !qual;
    assign tx_go     = st == WAIT_LOCK && qual && tcnt == LOCK_END;

    always_comb begin
        st_nxt   = st;
        tcnt_nxt = tcnt;
        case (st)
            PWRDN: begin
                st_nxt   = tcnt == PWR_END ? WAIT_LOCK : PWRDN;
                tcnt_nxt = tcnt == PWR_END ? '0 : tinc(tcnt);
            end
            WAIT_LOCK: begin
                st_nxt   = tx_go ? TX_UP : WAIT_LOCK;
                tcnt_nxt = qual && !tx_go ? tinc(tcnt) : '0;
            end
            TX_UP:   st_nxt = qual ? TX_UP : WAIT_LOCK;
            default: st_nxt = PWRDN;
        endcase
    end

    // A failed lane stays parked through lock loss; only reset or restart revives it.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            ls_nxt[i]    = ls[i];
            lcnt_nxt[i]  = linc(lcnt[i]);
            retry_nxt[i] = retry[i];
            if (lock_lost) begin
                ls_nxt[i]    = ls[i] == RX_FAIL ? RX_FAIL : RX_IDLE;
                lcnt_nxt[i]  = '0;
                retry_nxt[i] = '0;
            end else begin
                case (ls[i])
                    RX_IDLE: begin
                        ls_nxt[i]   = tx_go ? RX_ANA : RX_IDLE;
                        lcnt_nxt[i] = '0;
                    end
                    RX_ANA: if (lcnt[i] == ANA_END) begin
                        ls_nxt[i]   = RX_WAIT;
                        lcnt_nxt[i] = '0;
                    end
                    RX_WAIT: if (sync_status[i]) begin
                        ls_nxt[i]    = RX_UP;
                        lcnt_nxt[i]  = '0;
                        retry_nxt[i] = '0;
                    end else if (lcnt[i] == TO_END) begin
                        ls_nxt[i]    = rinc(retry[i]) == RETRY_END ? RX_FAIL : RX_ANA;
                        lcnt_nxt[i]  = '0;
                        retry_nxt[i] = rinc(retry[i]);
                    end
`ifdef XCVR_SYNC_DEBOUNCE_EN
                    RX_UP: if (sync_status[i]) begin
                        lcnt_nxt[i] = '0;
                    end else if (lcnt[i] == DEB_END) begin
                        ls_nxt[i]   = RX_ANA;
                        lcnt_nxt[i] = '0;
                    end
`else
                    RX_UP: begin
                        ls_nxt[i]   = sync_status[i] ? RX_UP : RX_ANA;
                        lcnt_nxt[i] = '0;
                    end
`endif
                    RX_FAIL: lcnt_nxt[i] = '0;
                    default: ls_nxt[i] = RX_IDLE;
                endcase
            end
        end
    end

    // Restart is registered so it takes effect as a reset one edge after it is sampled.
    always_ff @(posedge clk) begin
        restart_q <= rst_n && restart;
        if (!rst_n || restart_q) begin
            st             <= PWRDN;
            tcnt           <= '0;
            gxb_pwr_dwn    <= 1'b1;
            tx_digital_rst <= 1'b1;
            tx_ready       <= 1'b0;
            rx_analog_rst  <= '1;
            rx_digital_rst <= '1;
            rx_ready       <= '0;
            lane_fail      <= '0;
            retry_cnt      <= '0;
            for (int i = 0; i < LANES; i++) begin
                ls[i]    <= RX_IDLE;
                lcnt[i]  <= '0;
                retry[i] <= '0;
            end
        end else begin
            st             <= st_nxt;
            tcnt           <= tcnt_nxt;
            gxb_pwr_dwn    <= st_nxt == PWRDN;
            tx_digital_rst <= st_nxt != TX_UP;
            tx_ready       <= st_nxt == TX_UP;
            retry_cnt      <= retry_nxt[0];
            for (int i = 0; i < LANES; i++) begin
                ls[i]             <= ls_nxt[i];
                lcnt[i]           <= lcnt_nxt[i];
                retry[i]          <= retry_nxt[i];
                rx_analog_rst[i]  <= ls_nxt[i] != RX_WAIT && ls_nxt[i] != RX_UP;
                rx_digital_rst[i] <= ls_nxt[i] != RX_WAIT && ls_nxt[i] != RX_UP;
                rx_ready[i]       <= ls_nxt[i] == RX_UP;
                lane_fail[i]      <= ls_nxt[i] == RX_FAIL;
            end
        end
    end
endmodule

// File: tb/tb_xcver_rst_seq.sv
// tb_xcver_rst_seq: directed bring-up scenarios plus randomized stimulus against a timer-based model.
module tb_xcver_rst_seq;
    localparam int PWR = 16, LOCK = 100, ANA = 8, TO = 200, MAXR = 3, DEB = 8;
`ifdef XCVR_SYNC_DEBOUNCE_EN
    localparam int DROP = DEB;
`else
    localparam int DROP = 1;
`endif

    logic       clk = 0, rst_n = 0, restart = 0, pll_locked = 1, reconfig_busy = 0;
    logic [1:0] sync_status = 2'b11;
    logic       gxb_pwr_dwn, tx_digital_rst, tx_ready;
    logic [1:0] rx_analog_rst, rx_digital_rst, rx_ready, lane_fail;
    logic [3:0] retry_cnt;

    int tests = 0, fails = 0, cyc = 0;
    bit chk_en = 0;

    bit       m_pd = 1, m_tx = 0, rd = 0;
    int       pd_cnt = 0, lock_run = 0;
    int       ana_rem [2], wait_t [2], tries [2], low_run [2];
    bit [1:0] waiting = 0, up = 0, fail = 0;
    bit [1:0] e_rst;

    always #5 clk = ~clk;

    xcver_rst_seq #(
        .LANES(2), .PWR_DN_CYC(PWR), .LOCK_WAIT_CYC(LOCK), .RX_ANA_RST_CYC(ANA),
        .SYNC_TIMEOUT_CYC(TO), .MAX_RETRY(MAXR), .DEBOUNCE_CYC(DEB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart), .pll_locked(pll_locked),
        .reconfig_busy(reconfig_busy), .sync_status(sync_status), .gxb_pwr_dwn(gxb_pwr_dwn),
        .tx_digital_rst(tx_digital_rst), .tx_ready(tx_ready), .rx_analog_rst(rx_analog_rst),
        .rx_digital_rst(rx_digital_rst), .rx_ready(rx_ready), .lane_fail(lane_fail),
        .retry_cnt(retry_cnt)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, got, exp, cyc);
        end
    endtask

    // Model: each lane is described by remaining analog-reset time, sync wait age and attempts used.
    always @(posedge clk) begin : model
        bit q, go, lost;
        q    = pll_locked && !reconfig_busy;
        go   = 0;
        lost = 0;
        if (!rst_n || rd) begin
            m_pd = 1; pd_cnt = 0; m_tx = 0; lock_run = 0; waiting = 0; up = 0; fail = 0;
            for (int i = 0; i < 2; i++) begin
                ana_rem[i] = 0; wait_t[i] = 0; tries[i] = 0; low_run[i] = 0;
            end
        end else begin
            if (m_pd) begin
                pd_cnt++;
                if (pd_cnt == PWR) m_pd = 0;
            end else if (!m_tx) begin
                lock_run = q ? lock_run + 1 : 0;
                if (lock_run == LOCK) begin m_tx = 1; go = 1; end
            end else if (!q) begin
                m_tx = 0; lock_run = 0; lost = 1;
            end
            for (int i = 0; i < 2; i++) begin
                if (lost) begin
                    tries[i] = 0;
                    if (!fail[i]) begin ana_rem[i] = 0; waiting[i] = 0; up[i] = 0; end
                end else if (!fail[i]) begin
                    if (go) ana_rem[i] = ANA;
                    else if (ana_rem[i] > 0) begin
                        ana_rem[i]--;
                        if (ana_rem[i] == 0) begin waiting[i] = 1; wait_t[i] = 0; end
                    end else if (waiting[i]) begin
                        if (sync_status[i]) begin
                            waiting[i] = 0; up[i] = 1; tries[i] = 0; low_run[i] = 0;
                        end else begin
                            wait_t[i]++;
                            if (wait_t[i] == TO) begin
                                tries[i]++;
                                waiting[i] = 0;
                                if (tries[i] == MAXR) fail[i] = 1;
                                else ana_rem[i] = ANA;
                            end
                        end
                    end else if (up[i]) begin
                        low_run[i] = sync_status[i] ? 0 : low_run[i] + 1;
                        if (low_run[i] == DROP) begin up[i] = 0; low_run[i] = 0; ana_rem[i] = ANA; end
                    end
                end
            end
        end
        rd  = rst_n && restart;
        cyc = rst_n ? cyc + 1 : 0;
    end

    always @(negedge clk) if (chk_en) begin
        e_rst = ~(waiting | up);
        check("gxb_pwr_dwn", 32'(gxb_pwr_dwn), 32'(m_pd));
        check("tx_digital_rst", 32'(tx_digital_rst), 32'(!m_tx));
        check("tx_ready", 32'(tx_ready), 32'(m_tx));
        check("rx_analog_rst", 32'(rx_analog_rst), 32'(e_rst));
        check("rx_digital_rst", 32'(rx_digital_rst), 32'(e_rst));
        check("rx_ready", 32'(rx_ready), 32'(up));
        check("lane_fail", 32'(lane_fail), 32'(fail));
        check("retry_cnt", 32'(retry_cnt), 32'(tries[0]));
    end

    task automatic do_reset();
        @(negedge clk) rst_n = 0;
        @(negedge clk) rst_n = 1;
    endtask

    task automatic to_cyc(input int n);
        for (int k = 0; k < 100000 && cyc < n; k++) @(negedge clk);
        check("reach_cyc", 32'(cyc), 32'(n));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        chk_en = 1;
        // Clean bring-up, then a lock drop with both lanes up
        do_reset();
        check("reset_state", 32'({gxb_pwr_dwn, tx_digital_rst, tx_ready, rx_analog_rst,
              rx_digital_rst, rx_ready, lane_fail, retry_cnt}), 32'(15'b110_1111_0000_0000));
        to_cyc(15);  check("pwr_held", 32'(gxb_pwr_dwn), 1);
        to_cyc(16);  check("pwr_rel", 32'(gxb_pwr_dwn), 0);
        to_cyc(115); check("tx_early", 32'(tx_ready), 0);
        to_cyc(116); check("tx_up", 32'({tx_ready, tx_digital_rst}), 32'(2'b10));
        to_cyc(124); check("rx_early", 32'(rx_ready), 0);
        to_cyc(125); check("rx_up", 32'(rx_ready), 3);
        to_cyc(140); pll_locked = 0;
        to_cyc(141); check("lock_loss", 32'({tx_ready, tx_digital_rst, rx_ready, rx_analog_rst}),
                           32'(6'b01_0011));
        pll_locked = 1;
        to_cyc(240); check("relock_early", 32'(tx_ready), 0);
        to_cyc(241); check("relock", 32'(tx_ready), 1);
        to_cyc(250); check("relock_rx", 32'(rx_ready), 3);
        // Lock glitch at count 50
        do_reset();
        to_cyc(66);  pll_locked = 0;
        to_cyc(67);  pll_locked = 1;
        to_cyc(166); check("glitch_early", 32'(tx_ready), 0);
        to_cyc(167); check("glitch_up", 32'(tx_ready), 1);
        // Reconfig busy, then sync-loss handling
        do_reset();
        reconfig_busy = 1;
        to_cyc(200); reconfig_busy = 0;
        to_cyc(299); check("busy_early", 32'(tx_ready), 0);
        to_cyc(300); check("busy_up", 32'(tx_ready), 1);
        to_cyc(320); sync_status = 2'b10;
        to_cyc(321); check("short_loss", 32'(rx_ready[0]), 32'(DROP > 1));
        to_cyc(323); sync_status = 2'b11;
        to_cyc(340); sync_status = 2'b10;
        to_cyc(347); check("long_loss7", 32'(rx_ready[0]), 32'(DROP > 1));
        to_cyc(348); check("long_loss8", 32'(rx_ready[0]), 0);
        sync_status = 2'b11;
        // Lane 1 never syncs: three timeouts then failed; restart clears it
        sync_status = 2'b01;
        do_reset();
        to_cyc(739); check("fail_early", 32'(lane_fail), 0);
        to_cyc(740); check("fail_set", 32'({lane_fail, rx_ready, rx_analog_rst, rx_digital_rst, retry_cnt}),
                           32'(12'b10_01_10_10_0000));
        to_cyc(760); restart = 1; sync_status = 2'b10;
        to_cyc(761); restart = 0; check("restart_lag", 32'(lane_fail), 2);
        to_cyc(762); check("restart_clr", 32'({lane_fail, gxb_pwr_dwn, tx_ready}), 32'(4'b0010));
        to_cyc(1085); check("retry0", 32'(retry_cnt), 0);
        to_cyc(1086); check("retry1", 32'(retry_cnt), 1);
        sync_status = 2'b11;
        to_cyc(1095); check("retry_clr", 32'({retry_cnt, rx_ready[0]}), 32'(5'b0000_1));
        // Randomized segments
        for (int s = 0; s < 40; s++) begin
            int len, r;
            int md [2];
            int dl [2];
            len = $urandom_range(300, 1500);
            for (int i = 0; i < 2; i++) begin
                md[i] = $urandom_range(0, 3);
                dl[i] = $urandom_range(0, 400);
            end
            r = $urandom_range(0, 5);
            rst_n   = r != 0;
            restart = r == 1;
            for (int t = 0; t < len; t++) begin
                @(negedge clk);
                rst_n         = 1;
                restart       = 0;
                pll_locked    = $urandom_range(0, 399) != 0;
                reconfig_busy = $urandom_range(0, 299) == 0;
                for (int i = 0; i < 2; i++)
                    sync_status[i] = md[i] == 0 ? 1'b1 : md[i] == 1 ? 1'b0 :
                                     md[i] == 2 ? ($urandom_range(0, 39) != 0) : (t >= dl[i]);
            end
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
